// File: rtl/ifu_fetch.sv
// Instruction fetch unit: fetches one 32-bit word per PC over an AXI-lite style
// read channel and hands it to decode with a valid/ready handshake.
module ifu_fetch #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] NOP_INST  = 32'h0000_0013
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [CPU_WIDTH-1:0] i_pc,
    input  logic                 i_pc_valid,
    output logic [CPU_WIDTH-1:0] o_araddr,
    output logic                 o_arvalid,
    input  logic                 i_arready,
    input  logic [CPU_WIDTH-1:0] i_rdata,
    input  logic [1:0]           i_rresp,
    input  logic                 i_rvalid,
    output logic                 o_rready,
    output logic [CPU_WIDTH-1:0] o_inst,
    output logic [CPU_WIDTH-1:0] o_inst_pc,
    output logic                 o_inst_valid,
    input  logic                 i_idu_ready,
    output logic                 o_fetch_err
);

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        OUT
    } state_t;

    state_t               state;
    logic                 boot_flag;
    logic                 pend_vld;
    logic [CPU_WIDTH-1:0] pend_pc;
    logic [CPU_WIDTH-1:0] fetch_pc;

    logic                 in_idle;
    logic                 start;
    logic                 take_pend;
    logic                 take_new;
    logic [CPU_WIDTH-1:0] sel_pc;

    // Trigger priority in IDLE: boot, then the pending entry, then a fresh pulse.
    always_comb begin
        in_idle   = (state == IDLE);
        start     = in_idle && (boot_flag || pend_vld || i_pc_valid);
        take_pend = in_idle && !boot_flag && pend_vld;
        take_new  = in_idle && !boot_flag && !pend_vld && i_pc_valid;
        sel_pc    = take_pend ? pend_pc : i_pc;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            boot_flag    <= 1'b1;
            pend_vld     <= 1'b0;
            pend_pc      <= '0;
            fetch_pc     <= '0;
            o_araddr     <= '0;
            o_arvalid    <= 1'b0;
            o_rready     <= 1'b0;
            o_inst       <= '0;
            o_inst_pc    <= '0;
            o_inst_valid <= 1'b0;
            o_fetch_err  <= 1'b0;
        end else begin
            // A pulse not consumed directly is parked; latest PC wins.
            if (i_pc_valid && !take_new) begin
                pend_vld <= 1'b1;
                pend_pc  <= i_pc;
            end else if (take_pend) begin
                pend_vld <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        boot_flag <= 1'b0;
                        fetch_pc  <= sel_pc;
                        if (sel_pc[1:0] != 2'b00) begin
                            o_inst       <= NOP_INST;
                            o_inst_pc    <= sel_pc;
                            o_fetch_err  <= 1'b1;
                            o_inst_valid <= 1'b1;
                            state        <= OUT;
                        end else begin
                            o_araddr  <= sel_pc;
                            o_arvalid <= 1'b1;
                            state     <= AR;
                        end
                    end
                end
                AR: begin
                    if (i_arready) begin
                        o_arvalid <= 1'b0;
                        o_rready  <= 1'b1;
                        state     <= R;
                    end
                end
                R: begin
                    if (i_rvalid) begin
                        o_rready     <= 1'b0;
                        o_inst_pc    <= fetch_pc;
                        o_inst_valid <= 1'b1;
                        if (i_rresp == 2'b00) begin
                            o_inst      <= i_rdata;
                            o_fetch_err <= 1'b0;
                        end else begin
                            o_inst      <= NOP_INST;
                            o_fetch_err <= 1'b1;
                        end
                        state <= OUT;
                    end
                end
                OUT: begin
                    if (i_idu_ready) begin
                        o_inst_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: boot, backpressure, bus fault, misaligned PC,
// pending-PC overwrite and asynchronous reset in the address phase.
module tb_ifu_fetch;

    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] i_pc;
    logic        i_pc_valid;
    logic [31:0] o_araddr;
    logic        o_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rvalid;
    logic        o_rready;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_valid;
    logic        i_idu_ready;
    logic        o_fetch_err;

    int checks = 0;
    int errors = 0;
    int ar_hs  = 0;
    int arv_cycles = 0;
    int seen_10 = 0;

    ifu_fetch dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_pc         (i_pc),
        .i_pc_valid   (i_pc_valid),
        .o_araddr     (o_araddr),
        .o_arvalid    (o_arvalid),
        .i_arready    (i_arready),
        .i_rdata      (i_rdata),
        .i_rresp      (i_rresp),
        .i_rvalid     (i_rvalid),
        .o_rready     (o_rready),
        .o_inst       (o_inst),
        .o_inst_pc    (o_inst_pc),
        .o_inst_valid (o_inst_valid),
        .i_idu_ready  (i_idu_ready),
        .o_fetch_err  (o_fetch_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Bus activity monitor: address handshakes, cycles with arvalid, stale-PC fetches.
    always @(posedge i_clk) begin
        if (o_arvalid && i_arready) ar_hs <= ar_hs + 1;
        if (o_arvalid) arv_cycles <= arv_cycles + 1;
        if (o_arvalid && o_araddr == 32'h8000_0010) seen_10 <= seen_10 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic pulse_pc(input logic [31:0] pc);
        i_pc       = pc;
        i_pc_valid = 1'b1;
        tick();
        i_pc_valid = 1'b0;
    endtask

    task automatic handshake_out();
        i_idu_ready = 1'b1;
        tick();
        i_idu_ready = 1'b0;
        check("out_drop", {31'b0, o_inst_valid}, 32'd0);
    endtask

    int hs0;
    int arv0;

    initial begin
        i_rst_n     = 1'b0;
        i_pc        = 32'h8000_0000;
        i_pc_valid  = 1'b0;
        i_arready   = 1'b1;
        i_rdata     = '0;
        i_rresp     = 2'b00;
        i_rvalid    = 1'b0;
        i_idu_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_arvalid", {31'b0, o_arvalid},    32'd0);
        check("rst_rready",  {31'b0, o_rready},     32'd0);
        check("rst_ivalid",  {31'b0, o_inst_valid}, 32'd0);
        check("rst_err",     {31'b0, o_fetch_err},  32'd0);
        check("rst_araddr",  o_araddr,  32'd0);
        check("rst_inst",    o_inst,    32'd0);
        check("rst_inst_pc", o_inst_pc, 32'd0);

        // Boot fetch without any pc_valid pulse
        i_rst_n = 1'b1;
        tick();
        check("boot_arvalid", {31'b0, o_arvalid}, 32'd1);
        check("boot_araddr",  o_araddr, 32'h8000_0000);
        tick();
        check("boot_rready",  {31'b0, o_rready},  32'd1);
        check("boot_ar_drop", {31'b0, o_arvalid}, 32'd0);
        i_rvalid = 1'b1;
        i_rdata  = 32'h0010_0093;
        tick();
        i_rvalid = 1'b0;
        i_rdata  = '0;
        check("boot_ivalid",  {31'b0, o_inst_valid}, 32'd1);
        check("boot_inst",    o_inst,    32'h0010_0093);
        check("boot_inst_pc", o_inst_pc, 32'h8000_0000);
        check("boot_err",     {31'b0, o_fetch_err}, 32'd0);
        tick();
        tick();
        check("boot_hold", {31'b0, o_inst_valid}, 32'd1);
        handshake_out();

        // Backpressure on every channel
        i_arready = 1'b0;
        hs0 = ar_hs;
        pulse_pc(32'h8000_0100);
        for (int k = 0; k < 3; k++) begin
            check("bp_arvalid", {31'b0, o_arvalid}, 32'd1);
            check("bp_araddr",  o_araddr, 32'h8000_0100);
            tick();
        end
        i_arready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("bp_rready", {31'b0, o_rready},     32'd1);
            check("bp_no_out", {31'b0, o_inst_valid}, 32'd0);
            tick();
        end
        i_rvalid = 1'b1;
        i_rdata  = 32'h0000_A0B3;
        tick();
        i_rvalid = 1'b0;
        i_rdata  = 32'h1111_1111;
        for (int k = 0; k < 5; k++) begin
            check("bp_ivalid", {31'b0, o_inst_valid}, 32'd1);
            check("bp_inst",   o_inst, 32'h0000_A0B3);
            tick();
        end
        handshake_out();
        check("bp_one_hs", ar_hs - hs0, 32'd1);

        // Bus fault, also the three-cycle best-case latency
        pulse_pc(32'h8000_0200);
        tick();
        i_rvalid = 1'b1;
        i_rresp  = 2'b10;
        i_rdata  = 32'hDEAD_BEEF;
        tick();
        i_rvalid = 1'b0;
        i_rresp  = 2'b00;
        check("flt_ivalid",  {31'b0, o_inst_valid}, 32'd1);
        check("flt_inst",    o_inst,    32'h0000_0013);
        check("flt_err",     {31'b0, o_fetch_err}, 32'd1);
        check("flt_inst_pc", o_inst_pc, 32'h8000_0200);
        handshake_out();

        // Misaligned PC: straight to OUT, no bus access
        arv0 = arv_cycles;
        pulse_pc(32'h8000_0002);
        check("mis_ivalid",  {31'b0, o_inst_valid}, 32'd1);
        check("mis_err",     {31'b0, o_fetch_err},  32'd1);
        check("mis_inst",    o_inst,    32'h0000_0013);
        check("mis_inst_pc", o_inst_pc, 32'h8000_0002);
        handshake_out();
        check("mis_no_ar", arv_cycles - arv0, 32'd0);

        // Pending overwrite: 0x10 parked in R, replaced by 0x20 in OUT
        pulse_pc(32'h8000_0300);
        tick();
        pulse_pc(32'h8000_0010);
        check("pnd_in_r", {31'b0, o_rready}, 32'd1);
        i_rvalid = 1'b1;
        i_rdata  = 32'h0000_0333;
        tick();
        i_rvalid = 1'b0;
        pulse_pc(32'h8000_0020);
        check("pnd_first_pc",  o_inst_pc, 32'h8000_0300);
        check("pnd_first_err", {31'b0, o_fetch_err}, 32'd0);
        handshake_out();
        tick();
        check("pnd_arvalid", {31'b0, o_arvalid}, 32'd1);
        check("pnd_araddr",  o_araddr, 32'h8000_0020);
        tick();
        i_rvalid = 1'b1;
        i_rdata  = 32'h0000_0444;
        tick();
        i_rvalid = 1'b0;
        check("pnd_inst_pc", o_inst_pc, 32'h8000_0020);
        check("pnd_inst",    o_inst,    32'h0000_0444);
        handshake_out();
        tick();
        check("pnd_drained", {31'b0, o_arvalid}, 32'd0);
        check("pnd_no_10",   seen_10, 32'd0);

        // Asynchronous reset during the address phase
        i_arready = 1'b0;
        pulse_pc(32'h8000_0400);
        check("ar_rst_pre", {31'b0, o_arvalid}, 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("ar_rst_arvalid", {31'b0, o_arvalid},    32'd0);
        check("ar_rst_ivalid",  {31'b0, o_inst_valid}, 32'd0);
        i_pc = 32'h8000_0500;
        tick();
        i_rst_n   = 1'b1;
        i_arready = 1'b1;
        tick();
        check("reboot_arvalid", {31'b0, o_arvalid}, 32'd1);
        check("reboot_araddr",  o_araddr, 32'h8000_0500);
        tick();
        i_rvalid = 1'b1;
        i_rdata  = 32'h0000_0555;
        tick();
        i_rvalid = 1'b0;
        check("reboot_inst_pc", o_inst_pc, 32'h8000_0500);
        check("reboot_inst",    o_inst,    32'h0000_0555);
        handshake_out();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
